// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer
//
// Purpose:
//    Inter-stage pipeline register carrying an instruction word and its PC.
//    A main register (M) drives the outputs directly. A skid register (S)
//    catches the one entry that upstream may still hand over while M is stalled.
//    in_ready comes straight from a flop, so backpressure never chains
//    combinationally from stage to stage. Flush kills every held entry
//    synchronously.
//
// Ports:
//    i_clk        clock, rising edge
//    i_reset      asynchronous active-high reset
//    i_flush      synchronous kill of all held entries
//    i_in_valid   upstream presents an entry
//    o_in_ready   stage can accept (registered, = !S.valid)
//    i_instr_in   incoming instruction
//    i_pc_in      incoming PC
//    o_out_valid  main entry valid
//    i_out_ready  downstream accepts
//    o_instr_out  main entry instruction, BUBBLE_INSTR when invalid
//    o_pc_out     main entry PC (retained while invalid)
//    o_occupancy  entries held, 0..2
//    o_stall_cnt  saturating count of backpressured cycles
//
// Configuration:
//    PIPE_SKID_REG_STALL_CNT_EN - when defined, o_stall_cnt counts edges with
//    out_valid=1 and out_ready=0. It saturates at all-ones and only reset
//    clears it. When undefined, o_stall_cnt is tied to 0.

module pipe_skid_reg #(
   parameter int                   INSTR_W      = 32,
   parameter int                   PC_W         = 32,
   parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = '0,
   parameter logic [PC_W-1:0]      RESET_PC     = '0,
   parameter int                   CNT_W        = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_flush,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [INSTR_W-1:0] i_instr_in,
   input  logic [PC_W-1:0]    i_pc_in,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [INSTR_W-1:0] o_instr_out,
   output logic [PC_W-1:0]    o_pc_out,
   output logic [1:0]         o_occupancy,
   output logic [CNT_W-1:0]   o_stall_cnt
);

   logic               r_m_valid;
   logic [INSTR_W-1:0] r_m_instr;
   logic [PC_W-1:0]    r_m_pc;
   logic               r_s_valid;
   logic [INSTR_W-1:0] r_s_instr;
   logic [PC_W-1:0]    r_s_pc;

   logic w_in_fire;
   logic w_m_free;

   assign o_in_ready  = ~r_s_valid;
   assign w_in_fire   = i_in_valid & ~r_s_valid;
   // M can take a new entry when it is empty or its entry leaves this edge.
   assign w_m_free    = ~r_m_valid | i_out_ready;

   assign o_out_valid = r_m_valid;
   assign o_instr_out = r_m_instr;
   assign o_pc_out    = r_m_pc;
   assign o_occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_m_valid <= 1'b0;
         r_m_instr <= BUBBLE_INSTR;
         r_m_pc    <= RESET_PC;
         r_s_valid <= 1'b0;
         r_s_instr <= '0;
         r_s_pc    <= '0;
      end else if (i_flush) begin
         // An entry handshaken this edge is dropped; upstream counts it as consumed.
         r_m_valid <= 1'b0;
         r_m_instr <= BUBBLE_INSTR;
         r_s_valid <= 1'b0;
      end else if (w_m_free) begin
         if (r_s_valid) begin
            // S only fills while M is stalled, so it is always the older entry.
            r_m_valid <= 1'b1;
            r_m_instr <= r_s_instr;
            r_m_pc    <= r_s_pc;
            r_s_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_m_valid <= 1'b1;
            r_m_instr <= i_instr_in;
            r_m_pc    <= i_pc_in;
         end else begin
            r_m_valid <= 1'b0;
            r_m_instr <= BUBBLE_INSTR;
         end
      end else if (w_in_fire) begin
         r_s_valid <= 1'b1;
         r_s_instr <= i_instr_in;
         r_s_pc    <= i_pc_in;
      end
   end

`ifdef PIPE_SKID_REG_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
      end else if (r_m_valid && !i_out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg against a FIFO reference model

module tb_pipe_skid_reg;

   localparam int          INSTR_W  = 32;
   localparam int          PC_W     = 32;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] BUBBLE   = 32'h0;
   localparam logic [31:0] RST_PC   = 32'h0000_1000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instr_in;
   logic [PC_W-1:0]    pc_in;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] instr_out;
   logic [PC_W-1:0]    pc_out;
   logic [1:0]         occupancy;
   logic [CNT_W-1:0]   stall_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a FIFO of at most two entries, the last PC shown, and the stall count.
   entry_t      q[$];
   logic [31:0] m_last_pc;
   int          m_cnt;

   pipe_skid_reg #(
      .INSTR_W(INSTR_W), .PC_W(PC_W), .BUBBLE_INSTR(BUBBLE),
      .RESET_PC(RST_PC), .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_instr_in(instr_in), .i_pc_in(pc_in),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_instr_out(instr_out), .o_pc_out(pc_out),
      .o_occupancy(occupancy), .o_stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_last_pc = RST_PC;
      m_cnt     = 0;
   endtask

   task automatic check_outputs(input string where);
      logic [63:0] e_instr;
      logic [63:0] e_pc;
      logic [63:0] e_cnt;
      e_instr = (q.size() > 0) ? {32'h0, q[0].instr} : {32'h0, BUBBLE};
      e_pc    = (q.size() > 0) ? {32'h0, q[0].pc}    : {32'h0, m_last_pc};
`ifdef PIPE_SKID_REG_STALL_CNT_EN
      e_cnt   = 64'(m_cnt);
`else
      e_cnt   = 64'h0;
`endif
      check({where, ":out_valid"}, {63'h0, out_valid}, {63'h0, q.size() > 0});
      check({where, ":instr_out"}, {32'h0, instr_out}, e_instr);
      check({where, ":pc_out"},    {32'h0, pc_out},    e_pc);
      check({where, ":in_ready"},  {63'h0, in_ready},  {63'h0, q.size() < 2});
      check({where, ":occupancy"}, {62'h0, occupancy}, 64'(q.size()));
      check({where, ":stall_cnt"}, {60'h0, stall_cnt}, e_cnt);
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, then check.
   task automatic cycle(input string where, input logic iv, input logic [31:0] ins,
                        input logic [31:0] p, input logic ordy, input logic fl);
      int     pre;
      logic   do_in;
      logic   do_out;
      entry_t e;
      in_valid  = iv;
      instr_in  = ins;
      pc_in     = p;
      out_ready = ordy;
      flush     = fl;
      pre    = q.size();
      do_in  = iv && (pre < 2);
      do_out = (pre > 0) && ordy;
      if ((pre > 0) && !ordy && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
      if (fl) begin
         q.delete();
      end else begin
         if (do_out) void'(q.pop_front());
         if (do_in) begin
            e.instr = ins;
            e.pc    = p;
            q.push_back(e);
         end
      end
      if (q.size() > 0) m_last_pc = q[0].pc;
      @(posedge clk);
      @(negedge clk);
      check_outputs(where);
   endtask

   task automatic do_reset_async(input string where);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_outputs(where);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_outputs({where, "_hold"});
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr_in = '0; pc_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      reset = 1'b0;

      // Back-to-back streaming with out_ready held high.
      for (int i = 0; i < 4; i++)
         cycle("stream", 1'b1, 32'h2408_0001 + i, 32'h3000 + 4 * i, 1'b1, 1'b0);
      cycle("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Backpressure: A sits in M, B lands in S, C is held upstream, then release.
      cycle("bp_a", 1'b1, 32'hA, 32'h3000, 1'b0, 1'b0);
      cycle("bp_b", 1'b1, 32'hB, 32'h3004, 1'b0, 1'b0);
      cycle("bp_c_held", 1'b1, 32'hC, 32'h3008, 1'b0, 1'b0);
      cycle("bp_rel_a", 1'b1, 32'hC, 32'h3008, 1'b1, 1'b0);
      cycle("bp_rel_b", 1'b1, 32'hC, 32'h3008, 1'b1, 1'b0);
      cycle("bp_rel_c", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle("bp_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush while full with D offered: D must never appear.
      cycle("fl_a", 1'b1, 32'h11, 32'h3000, 1'b0, 1'b0);
      cycle("fl_b", 1'b1, 32'h12, 32'h3004, 1'b0, 1'b0);
      cycle("fl_d", 1'b1, 32'hD, 32'h3010, 1'b0, 1'b1);
      cycle("fl_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Simultaneous in_fire and out_fire with S empty.
      cycle("sim_1", 1'b1, 32'h21, 32'h4000, 1'b0, 1'b0);
      cycle("sim_2", 1'b1, 32'h22, 32'h4004, 1'b1, 1'b0);
      cycle("sim_3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges with both entries held.
      cycle("rst_a", 1'b1, 32'h31, 32'h5000, 1'b0, 1'b0);
      cycle("rst_b", 1'b1, 32'h32, 32'h5004, 1'b0, 1'b0);
      do_reset_async("rst_async");

      // Stall counter saturation, survives flush, cleared by reset.
      cycle("stall_load", 1'b1, 32'h41, 32'h6000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         cycle("stall_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle("stall_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle("stall_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      do_reset_async("stall_reset");

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++)
         cycle("rand", ($urandom_range(0, 3) != 0), $urandom, $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised inter-stage pipeline register carrying instruction word and PC, for use between any two stages (F/D, D/E, E/M, M/W).
- Replaces the plain write-enable stage register with a valid/ready handshake plus a 2-entry skid buffer. Backpressure is therefore registered and never combinationally chained across stages.
- Adds synchronous flush (bubble insertion) and an occupancy output.

Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC field width
- BUBBLE_INSTR, 0, instr_out value whenever out_valid=0 (nop)
- RESET_PC, 0, pc_out value after reset
- CNT_W, 16, stall counter width (optional feature only)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- instr_in  in  INSTR_W  incoming instruction
- pc_in  in  PC_W  incoming PC
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- instr_out  out  INSTR_W  main entry instruction; BUBBLE_INSTR when invalid
- pc_out  out  PC_W  main entry PC
- occupancy  out  2  entries held (0..2) = main_valid + skid_valid
- stall_cnt  out  CNT_W  backpressure cycle count (see Optional Feature)

Behaviour:
- Storage: main register M {valid, instr, pc} drives the outputs directly. Skid register S {valid, instr, pc} is internal.
- Reset (async): M.valid=0, S.valid=0, instr_out=BUBBLE_INSTR, pc_out=RESET_PC, S contents=0, stall_cnt=0. Resulting outputs: in_ready=1, out_valid=0, occupancy=0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority each edge: flush > normal update.
- Flush:
  - M.valid<=0, S.valid<=0, instr_out<=BUBBLE_INSTR; pc_out retained.
  - An entry handshaken in the same cycle (in_fire=1) is discarded; the upstream stage treats it as consumed.
  - An out_fire in the same cycle completes normally downstream.
- Normal update when M is free (out_fire | !M.valid):
  - S.valid=1: M<=S, S.valid<=0. No in_fire is possible, since in_ready=0.
  - else if in_fire: M<=in, M.valid<=1.
  - else: M.valid<=0, instr_out<=BUBBLE_INSTR, pc_out retained.
- Normal update when M is held (M.valid & !out_ready):
  - in_fire: S<=in, S.valid<=1.
  - M is unchanged.
- No state is ever overwritten without a handshake; entries are never dropped except by flush or reset. Order is strictly FIFO.
- Latency and throughput:
  - Empty stage: in_fire at edge N gives out_valid=1 after edge N.
  - Sustained throughput is 1 entry/cycle when out_ready=1.
- Ready timing: in_ready falls the cycle after S fills. Upstream may still fire once while M is stalled, and that entry lands in S. Full (occupancy=2) means in_ready=0.
- Reset mid-operation: all entries lost immediately, outputs take their reset values without waiting for clk.

Optional Feature:
- Macro: PIPE_SKID_REG_STALL_CNT_EN.
- Defined:
  - stall_cnt increments on every edge where out_valid=1 & out_ready=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset; flush does not clear it.
- Undefined: stall_cnt constant 0. The port remains present so instantiations do not change.

Test Plan:
- Reset: assert reset mid-cycle with occupancy=2 -> immediately out_valid=0, in_ready=1, occupancy=0, instr_out=0, pc_out=RESET_PC.
- Streaming: out_ready=1, send instr 0x24080001..0x24080004 with pc 0x3000..0x300C back-to-back -> each appears one cycle later in order, in_ready stays 1, occupancy=1.
- Backpressure/skid:
  - Setup: out_ready=0 with A(pc 0x3000) in M; send B(pc 0x3004).
  - Expected: occupancy=2, in_ready=0, C held upstream.
  - Release out_ready=1: sequence A, B, C, with no loss or duplicate.
- Flush: occupancy=2, flush=1 with in_valid=1 (D, pc 0x3010) -> next cycle out_valid=0, instr_out=0, occupancy=0, D never appears.
- Simultaneous: M valid, S empty, out_fire and in_fire same edge -> M replaced by new entry, occupancy stays 1.
- Stall counter (macro defined, CNT_W=4): hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 (saturated). Flush leaves 15; reset gives 0. Macro undefined -> stall_cnt=0 throughout.
